cci_mpf_prim_ram_rd_buffered: RTL and testbench

CCI_MPF_PRIM_RAM_RD_BUFFERED -- requirements
Module: cci_mpf_prim_ram_rd_buffered

---
 rtl/cci_mpf_prim_ram_rd_buffered.sv | 112 +++++++++++
 tb/tb_cci_mpf_prim_ram_rd_buffered.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_prim_ram_rd_buffered.sv
// Read front end for a fixed-latency RAM read port: tracks in-flight reads and
// buffers responses, issuing credits so the response buffer can never overflow.
module cci_mpf_prim_ram_rd_buffered #(
  parameter int unsigned N_ENTRIES           = 32,
  parameter int unsigned N_DATA_BITS         = 64,
  parameter int unsigned N_OUTPUT_REG_STAGES = 0,
  parameter int unsigned N_TAG_BITS          = 8,
  parameter int unsigned N_RSP_BUF_ENTRIES   = 4
) (
  input  logic                         clk0,
  input  logic                         reset,
  input  logic                         ram_rdy,
  input  logic                         req_valid,
  input  logic [$clog2(N_ENTRIES)-1:0] req_addr,
  input  logic [N_TAG_BITS-1:0]        req_tag,
  output logic                         req_ready,
  output logic [$clog2(N_ENTRIES)-1:0] ram_addr,
  input  logic [N_DATA_BITS-1:0]       ram_rdata,
  output logic                         rsp_valid,
  output logic [N_DATA_BITS-1:0]       rsp_data,
  output logic [N_TAG_BITS-1:0]        rsp_tag,
  input  logic                         rsp_ready
);

  localparam int unsigned LAT   = 1 + N_OUTPUT_REG_STAGES;
  localparam int unsigned PTR_W = (N_RSP_BUF_ENTRIES > 1) ? $clog2(N_RSP_BUF_ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(N_RSP_BUF_ENTRIES + 1);

  typedef struct packed {
    logic [N_DATA_BITS-1:0] data;
    logic [N_TAG_BITS-1:0]  tag;
  } rsp_t;

  logic [LAT-1:0]        pipe_v_q,   pipe_v_d;
  logic [N_TAG_BITS-1:0] pipe_tag_q [LAT];
  logic [N_TAG_BITS-1:0] pipe_tag_d [LAT];
  rsp_t                  buf_q      [N_RSP_BUF_ENTRIES];
  rsp_t                  buf_d      [N_RSP_BUF_ENTRIES];
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      fill_q,     fill_d;
  logic [CNT_W-1:0]      credit_q,   credit_d;
  logic                  live_q,     live_d;
  logic                  accept_c,   pop_c,   push_c;

  // Handshakes; credits cover in-flight reads plus buffered entries.
  always_comb begin
    req_ready = ram_rdy && !reset && live_q && (credit_q < CNT_W'(N_RSP_BUF_ENTRIES));
    rsp_valid = !reset && (fill_q != '0);
    rsp_data  = buf_q[rd_ptr_q].data;
    rsp_tag   = buf_q[rd_ptr_q].tag;
    ram_addr  = req_addr;
    accept_c  = req_valid && req_ready;
    pop_c     = rsp_valid && rsp_ready;
    push_c    = pipe_v_q[LAT-1];
  end

  // Next state: latency pipeline, response buffer and occupancy counters.
  always_comb begin
    pipe_v_d      = '0;
    pipe_tag_d    = pipe_tag_q;
    buf_d         = buf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    live_d        = 1'b1;

    pipe_v_d[0]   = accept_c;
    pipe_tag_d[0] = req_tag;
    for (int unsigned k = 1; k < LAT; k++) begin
      pipe_v_d[k]   = pipe_v_q[k-1];
      pipe_tag_d[k] = pipe_tag_q[k-1];
    end

    if (push_c) begin
      buf_d[wr_ptr_q].data = ram_rdata;
      buf_d[wr_ptr_q].tag  = pipe_tag_q[LAT-1];
      wr_ptr_d = (wr_ptr_q == PTR_W'(N_RSP_BUF_ENTRIES - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(N_RSP_BUF_ENTRIES - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    fill_d   = fill_q + CNT_W'(push_c) - CNT_W'(pop_c);
    credit_d = credit_q + CNT_W'(accept_c) - CNT_W'(pop_c);
  end

  // Control state; reset drops anything still in flight.
  always_ff @(posedge clk0) begin
    if (reset) begin
      pipe_v_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      credit_q <= '0;
      live_q   <= 1'b0;
    end else begin
      pipe_v_q <= pipe_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      credit_q <= credit_d;
      live_q   <= live_d;
    end
  end

  // Payload storage is only meaningful behind its valid bits.
  always_ff @(posedge clk0) begin
    pipe_tag_q <= pipe_tag_d;
    buf_q      <= buf_d;
  end

endmodule

// File: tb/tb_cci_mpf_prim_ram_rd_buffered.sv
// Bench for the buffered RAM read front end: two instances (latency 1 / buffer 4,
// latency 3 / buffer 8) checked every cycle against a queue model plus directed cases.
module tb_cci_mpf_prim_ram_rd_buffered;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 64;
  localparam int unsigned TW   = 8;
  localparam int unsigned SB_D = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          reset     [2];
  logic          ram_rdy   [2];
  logic          req_valid [2];
  logic [AW-1:0] req_addr  [2];
  logic [TW-1:0] req_tag   [2];
  logic          req_ready [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_rdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_data  [2];
  logic [TW-1:0] rsp_tag   [2];
  logic          rsp_ready [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk0) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a) * 64'h21;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned N_ORS = (g == 0) ? 0 : 2;
    localparam int unsigned NB    = (g == 0) ? 4 : 8;
    logic [AW-1:0] apipe [N_ORS+1];

    // Attached RAM: read data appears N_ORS+1 cycles after the address.
    always @(posedge clk0) begin
      apipe[0] <= ram_addr[g];
      for (int k = 1; k < N_ORS + 1; k++) apipe[k] <= apipe[k-1];
    end
    assign ram_rdata[g] = mem_word(apipe[N_ORS]);

    cci_mpf_prim_ram_rd_buffered #(
      .N_ENTRIES          (32),
      .N_DATA_BITS        (DW),
      .N_OUTPUT_REG_STAGES(N_ORS),
      .N_TAG_BITS         (TW),
      .N_RSP_BUF_ENTRIES  (NB)
    ) u_dut (
      .clk0     (clk0),
      .reset    (reset[g]),
      .ram_rdy  (ram_rdy[g]),
      .req_valid(req_valid[g]),
      .req_addr (req_addr[g]),
      .req_tag  (req_tag[g]),
      .req_ready(req_ready[g]),
      .ram_addr (ram_addr[g]),
      .ram_rdata(ram_rdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_data (rsp_data[g]),
      .rsp_tag  (rsp_tag[g]),
      .rsp_ready(rsp_ready[g])
    );
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Model: accepted-but-unpopped requests in order; size is the credit count.
  exp_t          sb       [2][SB_D];
  int            sb_rd    [2] = '{0, 0};
  int            sb_wr    [2] = '{0, 0};
  bit            post_rst [2] = '{1'b1, 1'b1};
  bit            stalled  [2] = '{1'b0, 1'b0};
  logic [DW-1:0] held_d   [2];
  logic [TW-1:0] held_t   [2];

  always @(negedge clk0) begin
    int   lat, nb, occ;
    bit   exp_rdy, exp_v;
    exp_t h;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      nb  = (i == 0) ? 4 : 8;
      occ = sb_wr[i] - sb_rd[i];
      check_eq("ram_addr", 64'(ram_addr[i]), 64'(req_addr[i]));
      if (reset[i]) begin
        check_eq("reset_req_ready", 64'(req_ready[i]), 64'(0));
        check_eq("reset_rsp_valid", 64'(rsp_valid[i]), 64'(0));
        sb_rd[i]    = sb_wr[i];
        post_rst[i] = 1'b1;
        stalled[i]  = 1'b0;
      end else begin
        exp_rdy = ram_rdy[i] && !post_rst[i] && (occ < nb);
        check_eq("req_ready", 64'(req_ready[i]), 64'(exp_rdy));
        h     = sb[i][sb_rd[i] % SB_D];
        exp_v = (occ > 0) && (h.cyc + lat + 1 <= cyc);
        check_eq("rsp_valid", 64'(rsp_valid[i]), 64'(exp_v));
        if (stalled[i] && rsp_valid[i]) begin
          check_eq("stall_data", rsp_data[i], held_d[i]);
          check_eq("stall_tag", 64'(rsp_tag[i]), 64'(held_t[i]));
        end
        if (rsp_valid[i] && rsp_ready[i] && occ > 0) begin
          check_eq("rsp_data", rsp_data[i], h.data);
          check_eq("rsp_tag", 64'(rsp_tag[i]), 64'(h.tag));
          sb_rd[i]++;
        end
        if (req_valid[i] && req_ready[i]) begin
          sb[i][sb_wr[i] % SB_D].data = mem_word(req_addr[i]);
          sb[i][sb_wr[i] % SB_D].tag  = req_tag[i];
          sb[i][sb_wr[i] % SB_D].cyc  = cyc;
          sb_wr[i]++;
        end
        stalled[i]  = rsp_valid[i] && !rsp_ready[i];
        held_d[i]   = rsp_data[i];
        held_t[i]   = rsp_tag[i];
        post_rst[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic drain(input int i);
    int n;
    rsp_ready[i] = 1'b1;
    req_valid[i] = 1'b0;
    n = 0;
    while ((sb_wr[i] != sb_rd[i]) && n < 200) begin
      tick();
      n++;
    end
    if (sb_wr[i] != sb_rd[i]) fail_now("drain");
    tick();
    tick();
  endtask

  logic [DW-1:0] r40_exp [8] = '{64'h00, 64'h21, 64'h42, 64'h63, 64'h84, 64'hA5, 64'hC6, 64'hE7};

  initial begin
    int            nacc, rsp_n, t0, n;
    int            acc_cyc [8];
    int            rsp_cyc [8];
    logic [DW-1:0] rsp_d   [8];
    logic [TW-1:0] rsp_t   [8];

    for (int i = 0; i < 2; i++) begin
      reset[i]     = 1'b1;
      ram_rdy[i]   = 1'b1;
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      req_tag[i]   = '0;
      rsp_ready[i] = 1'b1;
    end
    ram_rdy[0]   = 1'b0;
    req_valid[0] = 1'b1;
    req_addr[0]  = 5'd1;
    req_tag[0]   = 8'h11;
    repeat (3) tick();
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // RAM not ready: no accepts for 40 cycles, then accept the same cycle it rises.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk0);
      check_eq("ramrdy_low_req_ready", 64'(req_ready[0]), 64'(0));
      tick();
    end
    ram_rdy[0] = 1'b1;
    @(negedge clk0);
    check_eq("ramrdy_first_accept", 64'(req_ready[0]), 64'(1));
    tick();
    drain(0);

    // Single read, latency 1: response two cycles after accept, for one cycle.
    req_addr[0]  = 5'd5;
    req_tag[0]   = 8'h03;
    req_valid[0] = 1'b1;
    @(negedge clk0);
    check_eq("single_accept", 64'(req_ready[0]), 64'(1));
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk0);
    check_eq("single_t1_valid", 64'(rsp_valid[0]), 64'(0));
    tick();
    @(negedge clk0);
    check_eq("single_t2_valid", 64'(rsp_valid[0]), 64'(1));
    check_eq("single_t2_data", rsp_data[0], 64'hA5);
    check_eq("single_t2_tag", 64'(rsp_tag[0]), 64'h03);
    tick();
    @(negedge clk0);
    check_eq("single_t3_valid", 64'(rsp_valid[0]), 64'(0));
    tick();

    // Credit exhaustion: 6 offers with consumer stalled, 4 taken.
    rsp_ready[0] = 1'b0;
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid[0] = 1'b1;
      req_addr[0]  = AW'(10 + k);
      req_tag[0]   = TW'(8'h20 + k);
      @(negedge clk0);
      if (req_valid[0] && req_ready[0]) nacc++;
      tick();
    end
    req_valid[0] = 1'b0;
    check_eq("full_accept_count", 64'(nacc), 64'(4));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk0);
      check_eq("full_req_ready", 64'(req_ready[0]), 64'(0));
      tick();
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk0);
    check_eq("full_pop_valid", 64'(rsp_valid[0]), 64'(1));
    check_eq("full_pop_cycle_ready", 64'(req_ready[0]), 64'(0));
    tick();
    rsp_ready[0] = 1'b0;
    @(negedge clk0);
    check_eq("full_after_pop_ready", 64'(req_ready[0]), 64'(1));
    tick();
    drain(0);

    // Latency 3: back-to-back addrs 0..7, response at accept+4, one per cycle.
    drain(1);
    nacc  = 0;
    rsp_n = 0;
    for (int c = 0; c < 40 && rsp_n < 8; c++) begin
      req_valid[1] = (nacc < 8);
      req_addr[1]  = AW'(nacc);
      req_tag[1]   = TW'(8'h40 + nacc);
      @(negedge clk0);
      if (req_valid[1] && req_ready[1]) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (rsp_valid[1] && rsp_ready[1] && rsp_n < 8) begin
        rsp_cyc[rsp_n] = cyc;
        rsp_d[rsp_n]   = rsp_data[1];
        rsp_t[rsp_n]   = rsp_tag[1];
        rsp_n++;
      end
      tick();
    end
    req_valid[1] = 1'b0;
    check_eq("b2b_rsp_count", 64'(rsp_n), 64'(8));
    for (int k = 0; k < rsp_n; k++) begin
      if (k > 0) check_eq("b2b_accept_cycle", 64'(acc_cyc[k]), 64'(acc_cyc[0] + k));
      check_eq("b2b_rsp_cycle", 64'(rsp_cyc[k]), 64'(acc_cyc[0] + 4 + k));
      check_eq("b2b_rsp_data", rsp_d[k], r40_exp[k]);
      check_eq("b2b_rsp_tag", 64'(rsp_t[k]), 64'(8'h40 + k));
    end
    drain(1);

    // Reset with 2 reads in flight and 3 buffered.
    rsp_ready[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_valid[1] = 1'b1;
      req_addr[1]  = AW'(20 + k);
      req_tag[1]   = TW'(8'h60 + k);
      @(negedge clk0);
      check_eq("rst_fill_accept", 64'(req_ready[1]), 64'(1));
      tick();
    end
    req_valid[1] = 1'b0;
    tick();
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk0);
      check_eq("rst_no_stale_valid", 64'(rsp_valid[1]), 64'(0));
      if (k == 0) check_eq("rst_first_cycle_ready", 64'(req_ready[1]), 64'(0));
      tick();
    end
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid[1] = 1'b1;
      req_addr[1]  = (nacc == 0) ? 5'd7 : AW'(nacc);
      req_tag[1]   = (nacc == 0) ? 8'h77 : TW'(8'h80 + nacc);
      @(negedge clk0);
      if (req_valid[1] && req_ready[1]) nacc++;
      tick();
    end
    req_valid[1] = 1'b0;
    check_eq("rst_credit_count", 64'(nacc), 64'(8));
    rsp_ready[1] = 1'b1;
    @(negedge clk0);
    check_eq("rst_next_valid", 64'(rsp_valid[1]), 64'(1));
    check_eq("rst_next_data", rsp_data[1], 64'hE7);
    check_eq("rst_next_tag", 64'(rsp_tag[1]), 64'h77);
    tick();
    drain(1);

    // Random traffic with consumer and RAM-ready toggling.
    for (int i = 0; i < 2; i++) begin
      nacc = 0;
      n    = 0;
      while (nacc < 1000 && n < 20000) begin
        req_valid[i] = ($urandom_range(3) != 0);
        req_addr[i]  = AW'($urandom);
        req_tag[i]   = TW'($urandom);
        rsp_ready[i] = 1'($urandom_range(1));
        ram_rdy[i]   = ($urandom_range(15) != 0);
        @(negedge clk0);
        if (req_valid[i] && req_ready[i]) nacc++;
        tick();
        n++;
      end
      if (nacc < 1000) fail_now("random_accepts");
      ram_rdy[i] = 1'b1;
      drain(i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
